// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and constants for the CPU bus arbiter family.
package cpu_arb_package;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Read data returned to a master whose transfer was aborted.
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    // Bit offset of element 'index' inside a packed vector of 'width'-bit fields.
    function automatic int slice_offset(input int index, input int width);
        return index * width;
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_rr_pick.sv
// bus_rr_pick: combinational round-robin picker. Returns the first requester
// at or after the pointer, wrapping modulo NumMasters.
module bus_rr_pick #(
    parameter int NumMasters = 2,
    parameter int IndexWidth = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
    input  logic [NumMasters-1:0] req_i,
    input  logic [IndexWidth-1:0] ptr_i,
    output logic                  valid_o,
    output logic [IndexWidth-1:0] idx_o
);

    localparam logic [IndexWidth:0] Modulus = (IndexWidth + 1)'(NumMasters);

    logic [2*NumMasters-1:0] req_dbl;
    logic [NumMasters-1:0]   req_rot;
    logic [IndexWidth-1:0]   offset;
    logic [IndexWidth:0]     sum;

    // Rotate so that bit 0 is the requester at the pointer.
    assign req_dbl = {req_i, req_i};
    assign req_rot = NumMasters'(req_dbl >> ptr_i);

    // Lowest set bit of the rotated vector is the distance from the pointer.
    always_comb begin
        offset = '0;
        for (int k = NumMasters - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = IndexWidth'(k);
            end
        end
    end

    // Both operands are below NumMasters, so one conditional subtract wraps.
    assign sum     = {1'b0, ptr_i} + {1'b0, offset};
    assign valid_o = |req_i;
    assign idx_o   = (sum >= Modulus) ? IndexWidth'(sum - Modulus) : sum[IndexWidth-1:0];

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin arbiter serialising NumMasters requesters onto
// the single peripheral CPU bus. One strobe per transfer, waits out downstream
// busy, returns read data and acks the winner. Losing requesters are halted.
// Optional busy timeout abort is enabled by defining ARB_TIMEOUT_EN.
module cpu_bus_arbiter
    import cpu_arb_package::*;
#(
    parameter int  NumMasters    = 2,
    parameter int  AddressWidth  = 32,
    parameter int  DataWidth     = 32,
    parameter int  ReadLatency   = 1,
    parameter int  TimeoutCycles = 1024,
    localparam int GrantWidth    = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic [NumMasters-1:0]              m_req_i,
    input  logic [NumMasters-1:0]              m_we_i,
    input  logic [NumMasters*AddressWidth-1:0] m_address_i,
    input  logic [NumMasters*DataWidth-1:0]    m_data_i,
    output logic [NumMasters-1:0]              m_ack_o,
    output logic [DataWidth-1:0]               m_data_o,
    output logic [NumMasters-1:0]              m_halt_o,
    output logic [AddressWidth-1:0]            bus_address_o,
    output logic [DataWidth-1:0]               bus_data_o,
    output logic                               bus_we_o,
    output logic                               bus_stb_o,
    input  logic [DataWidth-1:0]               bus_data_i,
    input  logic                               bus_busy_i,
    output logic [GrantWidth-1:0]              grant_o,
    output logic                               err_o
);

    localparam int QualWidth = $clog2(ReadLatency + 1);

    arb_state_t              state_reg, state_next;
    logic [GrantWidth-1:0]   grant_reg, grant_next;
    logic [GrantWidth-1:0]   ptr_reg, ptr_next;
    logic [AddressWidth-1:0] addr_reg, addr_next;
    logic [DataWidth-1:0]    wdata_reg, wdata_next;
    logic [DataWidth-1:0]    rdata_reg, rdata_next;
    logic                    we_reg, we_next;
    logic [QualWidth-1:0]    qual_reg, qual_next;
    logic [QualWidth-1:0]    qual_target;

`ifdef ARB_TIMEOUT_EN
    localparam int                   TmoWidth = $clog2(TimeoutCycles + 1);
    localparam logic [DataWidth-1:0] ErrData  = DataWidth'(BUS_ERR_DATA);

    logic [TmoWidth-1:0] tmo_reg, tmo_next;
    logic                err_reg, err_next;
`endif

    logic                    pick_valid;
    logic [GrantWidth-1:0]   pick_idx;
    logic [AddressWidth-1:0] m_addr_arr [NumMasters];
    logic [DataWidth-1:0]    m_data_arr [NumMasters];

    bus_rr_pick #(
        .NumMasters (NumMasters),
        .IndexWidth (GrantWidth)
    ) u_pick (
        .req_i   (m_req_i),
        .ptr_i   (ptr_reg),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Per-master unpacking of payloads, ack decode and halt.
    genvar gi;
    generate
        for (gi = 0; gi < NumMasters; gi++) begin : g_master
            assign m_addr_arr[gi] = m_address_i[slice_offset(gi, AddressWidth) +: AddressWidth];
            assign m_data_arr[gi] = m_data_i[slice_offset(gi, DataWidth) +: DataWidth];
            assign m_ack_o[gi]    = (state_reg == DONE) && (grant_reg == GrantWidth'(gi));
            assign m_halt_o[gi]   = m_req_i[gi] & ~m_ack_o[gi];
        end
    endgenerate

    assign bus_stb_o     = (state_reg == ISSUE);
    assign bus_address_o = addr_reg;
    assign bus_data_o    = wdata_reg;
    assign bus_we_o      = we_reg;
    assign grant_o       = grant_reg;
    assign m_data_o      = rdata_reg;

`ifdef ARB_TIMEOUT_EN
    assign err_o = (state_reg == DONE) && err_reg;
`else
    assign err_o = 1'b0;
`endif

    // Writes need a single qualifying cycle; reads wait ReadLatency of them.
    assign qual_target = we_reg ? QualWidth'(1) : QualWidth'(ReadLatency);

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        we_next    = we_reg;
        qual_next  = qual_reg;
`ifdef ARB_TIMEOUT_EN
        tmo_next   = tmo_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_idx;
                    addr_next  = m_addr_arr[pick_idx];
                    wdata_next = m_data_arr[pick_idx];
                    we_next    = m_we_i[pick_idx];
                    qual_next  = '0;
`ifdef ARB_TIMEOUT_EN
                    tmo_next   = '0;
                    err_next   = 1'b0;
`endif
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (!bus_busy_i) begin
`ifdef ARB_TIMEOUT_EN
                    tmo_next = '0;
`endif
                    if (qual_reg + QualWidth'(1) == qual_target) begin
                        qual_next  = '0;
                        rdata_next = we_reg ? '0 : bus_data_i;
                        state_next = DONE;
                    end else begin
                        qual_next = qual_reg + QualWidth'(1);
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_reg == TmoWidth'(TimeoutCycles - 1)) begin
                    tmo_next   = '0;
                    err_next   = 1'b1;
                    rdata_next = ErrData;
                    state_next = DONE;
                end else begin
                    tmo_next = tmo_reg + TmoWidth'(1);
                end
`endif
            end
            DONE: begin
                ptr_next   = (grant_reg == GrantWidth'(NumMasters - 1)) ? '0
                                                                        : grant_reg + GrantWidth'(1);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            we_reg    <= 1'b0;
            qual_reg  <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_reg   <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            we_reg    <= we_next;
            qual_reg  <= qual_next;
`ifdef ARB_TIMEOUT_EN
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
`endif
        end
    end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Round-robin arbiter that shares the single peripheral CPU bus (address/data/we, as fed into the CDC bridge and IO block) between NumMasters requesters, e.g. the RV32 core and a UART debug master.
- Serialises transfers one at a time and issues a single strobe per transfer.
- Waits out downstream busy (CDC bridge busy), returns read data and acks the winner.
- Stalls losing requesters via per-master halt outputs.

Parameters:
- NumMasters, 2, number of requesters (2..8).
- AddressWidth, 32, bus address width.
- DataWidth, 32, bus data width.
- ReadLatency, 1, qualifying (busy-low) WAIT cycles before read data is valid. Minimum 1.
- TimeoutCycles, 1024, consecutive busy-high WAIT cycles before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- m_req_i  in  NumMasters  per-master request; held with payload until ack
- m_we_i  in  NumMasters  per-master write enable
- m_address_i  in  NumMasters*AddressWidth  packed per-master addresses, master 0 in the LSBs
- m_data_i  in  NumMasters*DataWidth  packed per-master write data
- m_ack_o  out  NumMasters  one-cycle completion pulse to the winner
- m_data_o  out  DataWidth  read data, shared; valid with ack
- m_halt_o  out  NumMasters  stall to requesting masters not being acked
- bus_address_o  out  AddressWidth  downstream address
- bus_data_o  out  DataWidth  downstream write data
- bus_we_o  out  1  downstream write enable
- bus_stb_o  out  1  one-cycle transfer strobe
- bus_data_i  in  DataWidth  downstream read data
- bus_busy_i  in  1  downstream busy (e.g. CDC bridge busy_o)
- grant_o  out  $clog2(NumMasters)  index of current or last winner
- err_o  out  1  timeout error pulse, coincident with ack

Behaviour:
- Reset (async, reset_ni=0): state IDLE; all outputs 0; round-robin pointer 0; latency and timeout counters 0. Reset mid-transfer drops stb/ack immediately; the aborted transfer is never acked.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any m_req_i is set, pick the first requester at or after the pointer, wrapping modulo NumMasters.
  - Latch the winner's address, data and we into registers; set grant_o; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: bus_stb_o=1 for exactly one cycle; bus_* driven from the latched registers; go to WAIT.
- WAIT:
  - bus_address_o, bus_data_o and bus_we_o held stable; bus_stb_o=0.
  - Each cycle with bus_busy_i=0 increments the qualify counter. Cycles with busy=1 freeze it.
  - Exit when the counter reaches 1 (write) or ReadLatency (read).
  - On the exiting edge, reads capture bus_data_i into the m_data_o register.
  - Go to DONE.
- DONE:
  - m_ack_o[grant]=1 for one cycle.
  - m_data_o holds the read data, or 0 for writes, until the next ack.
  - Pointer = (grant+1) mod NumMasters; go to IDLE.
- Latency, request seen at cycle c with busy low: stb at c+1; write ack at c+3; read ack at c+2+ReadLatency. Back-to-back transfers have 4 cycles minimum spacing (ack cycle, then IDLE).
- m_halt_o[i] = m_req_i[i] & ~m_ack_o[i], combinational.
- Requests arriving outside IDLE wait.
- A request deasserted before ack does not cancel the transfer: the bus transfer completes and the ack pulse still fires; the master ignores it.
- With NumMasters=1 the pointer is fixed at 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A second counter counts consecutive WAIT cycles with bus_busy_i=1; it resets on any busy-low cycle.
  - On reaching TimeoutCycles, go to DONE with err_o=1 alongside ack; m_data_o = BUS_ERR_DATA (32'hDEAD_BEEF truncated/zero-extended to DataWidth).
  - Pointer advances normally.
- Not defined: err_o tied 0; no timeout counter; WAIT holds indefinitely while busy.

Decomposition:
- Shared package (cpu_arb_package):
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - BUS_ERR_DATA constant.
  - Function for the packed-vector slice offset.
- Sub-module bus_rr_pick: combinational round-robin picker. Inputs: request vector and pointer. Outputs: valid flag and winner index. Reused by future interrupt and DMA arbiters.

Test Plan:
- Master 0 writes addr 0x9004, data 0x1234_5678, busy low -> stb at c+1 with those values, m_ack_o=01 at c+3, grant_o=0.
- Both masters request reads continuously, ReadLatency=2, bus_data_i=0xA5A5_0000+grant -> grants alternate 0,1,0,1. Each ack at c+4 of its own IDLE cycle, carrying data 0xA5A5_0000 or 0xA5A5_0001; the loser's m_halt_o stays high until its ack.
- Read with bus_busy_i held high 20 cycles after stb -> address held stable, no ack during busy; ack 2 cycles after busy falls (ReadLatency=1), data captured correctly.
- Master 1 drops req one cycle after stb -> transfer completes, m_ack_o=10 still pulses once, then pointer=0.
- reset_ni pulsed low during WAIT -> all outputs 0 asynchronously, no ack afterwards, next request arbitrated from pointer 0.
- ARB_TIMEOUT_EN, TimeoutCycles=16, busy stuck high -> ack and err_o together after 16 busy cycles in WAIT, m_data_o=0xDEAD_BEEF. Without the macro: no ack after 1000 cycles, err_o=0.
